// File: rtl/dm_sb_responder_pkg.sv
// Shared helpers for the debug system-bus responder: bus geometry and
// parameter legality checks used at elaboration time.
package dm_sb_responder_pkg;

    localparam int unsigned ByteBits = 8;

    // Number of address LSBs below word granularity for a given bus width.
    function automatic int unsigned word_shift(input int unsigned bus_width);
        return (bus_width == 64) ? 3 : 2;
    endfunction

    function automatic bit bus_width_legal(input int unsigned bus_width);
        return (bus_width == 32) || (bus_width == 64);
    endfunction

endpackage

// File: rtl/dm_sb_resp_pipe.sv
// Fixed-depth delay line for bus responses: a valid flag plus an opaque
// payload. Reset clears every stage so nothing in flight survives it.
module dm_sb_resp_pipe #(
    parameter int unsigned Depth = 1,
    parameter int unsigned Width = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_valid,
    input  logic [Width-1:0] push_data,
    output logic             pop_valid,
    output logic [Width-1:0] pop_data
);

    logic [Depth-1:0]            valid_reg;
    logic [Depth-1:0][Width-1:0] data_reg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_reg <= '0;
            data_reg  <= '0;
        end else begin
            valid_reg[0] <= push_valid;
            data_reg[0]  <= push_data;
            for (int i = 1; i < int'(Depth); i++) begin
                valid_reg[i] <= valid_reg[i-1];
                data_reg[i]  <= data_reg[i-1];
            end
        end
    end

    assign pop_valid = valid_reg[Depth-1];
    assign pop_data  = data_reg[Depth-1];

endmodule

// File: rtl/dm_sb_responder.sv
// Memory-backed system-bus target answering the debug module's SBA
// req/gnt/r_valid protocol, with programmable grant stall and response latency.
module dm_sb_responder
    import dm_sb_responder_pkg::*;
#(
    parameter int unsigned BusWidth    = 32,
    parameter int unsigned MemDepth    = 256,
    parameter logic [63:0] BaseAddr    = 64'h0,
    parameter int unsigned GntStall    = 0,
    parameter int unsigned RespLatency = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  slave_req_i,
    input  logic [BusWidth-1:0]   slave_add_i,
    input  logic                  slave_we_i,
    input  logic [BusWidth-1:0]   slave_wdata_i,
    input  logic [BusWidth/8-1:0] slave_be_i,
    output logic                  slave_gnt_o,
    output logic                  slave_r_valid_o,
    output logic [BusWidth-1:0]   slave_r_rdata_o,
    output logic                  slave_r_err_o
);

    localparam int unsigned NumBytes = BusWidth / ByteBits;
    localparam int unsigned Shift    = word_shift(BusWidth);
    localparam int unsigned IdxW     = (MemDepth > 1) ? $clog2(MemDepth) : 1;
    localparam logic [BusWidth-1:0] Base       = BaseAddr[BusWidth-1:0];
    localparam logic [BusWidth-1:0] DepthWords = BusWidth'(MemDepth);

    typedef struct packed {
        logic                err;
        logic [BusWidth-1:0] rdata;
    } resp_t;

    if (RespLatency < 1) begin : g_bad_latency
        $error("dm_sb_responder: RespLatency must be at least 1");
    end
    if (!bus_width_legal(BusWidth)) begin : g_bad_width
        $error("dm_sb_responder: BusWidth must be 32 or 64");
    end
    if (BaseAddr[Shift-1:0] != '0) begin : g_bad_base
        $error("dm_sb_responder: BaseAddr not aligned to the bus word");
    end

    // ---------------- grant ----------------
    logic gnt;
    logic xfer;

    if (GntStall == 0) begin : g_no_stall
        assign gnt = slave_req_i;
    end else begin : g_stall
        localparam int unsigned CntW = $clog2(GntStall + 1);
        logic [CntW-1:0] cnt_reg;
        logic [CntW-1:0] cnt_next;

        // A withdrawn request or a completed transfer restarts the stall.
        always_comb begin
            cnt_next = cnt_reg;
            if (!slave_req_i || gnt) begin
                cnt_next = '0;
            end else begin
                cnt_next = cnt_reg + 1'b1;
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                cnt_reg <= '0;
            end else begin
                cnt_reg <= cnt_next;
            end
        end

        assign gnt = slave_req_i && (cnt_reg == CntW'(GntStall));
    end

    assign slave_gnt_o = gnt;
    assign xfer        = slave_req_i && gnt;

    // ---------------- decode ----------------
    logic [BusWidth-1:0] offset;
    logic [BusWidth-1:0] word_off;
    logic                in_range;
    logic [IdxW-1:0]     idx;
    logic                wr_hit;
    logic                rd_hit;

    assign offset   = slave_add_i - Base;
    assign word_off = offset >> Shift;
    assign in_range = (slave_add_i >= Base) && (word_off < DepthWords);
    assign idx      = word_off[IdxW-1:0];
    assign wr_hit   = xfer && slave_we_i && in_range;
    assign rd_hit   = xfer && !slave_we_i && in_range;

    // ---------------- storage ----------------
    logic [NumBytes-1:0] byte_we;

    for (genvar gi = 0; gi < NumBytes; gi++) begin : g_byte_we
        assign byte_we[gi] = wr_hit && slave_be_i[gi];
    end

    logic [BusWidth-1:0] mem [MemDepth];
    logic [BusWidth-1:0] rd_word_reg;

    // Single port: a cycle either writes or reads, so a read granted right
    // after a write already sees the updated word.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < int'(NumBytes); b++) begin
            if (byte_we[b]) begin
                mem[idx][b*ByteBits +: ByteBits] <= slave_wdata_i[b*ByteBits +: ByteBits];
            end
        end
        if (rd_hit) begin
            rd_word_reg <= mem[idx];
        end
    end

    // ---------------- first response stage ----------------
    logic  head_valid_reg;
    logic  head_err_reg;
    logic  head_read_reg;
    resp_t head_resp;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_valid_reg <= 1'b0;
            head_err_reg   <= 1'b0;
            head_read_reg  <= 1'b0;
        end else begin
            head_valid_reg <= xfer;
            head_err_reg   <= xfer && !in_range;
            head_read_reg  <= rd_hit;
        end
    end

    // Writes and out-of-range accesses answer with zero data.
    assign head_resp.err   = head_err_reg;
    assign head_resp.rdata = head_read_reg ? rd_word_reg : '0;

    // ---------------- remaining latency ----------------
    if (RespLatency <= 1) begin : g_direct
        assign slave_r_valid_o = head_valid_reg;
        assign slave_r_err_o   = head_resp.err;
        assign slave_r_rdata_o = head_resp.rdata;
    end else begin : g_pipe
        resp_t tail_resp;

        dm_sb_resp_pipe #(
            .Depth (RespLatency - 1),
            .Width ($bits(resp_t))
        ) u_resp_pipe (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .push_valid (head_valid_reg),
            .push_data  (head_resp),
            .pop_valid  (slave_r_valid_o),
            .pop_data   (tail_resp)
        );

        assign slave_r_err_o   = tail_resp.err;
        assign slave_r_rdata_o = tail_resp.rdata;
    end

endmodule

// File: tb/tb_dm_sb_responder.sv
// Randomised bench for dm_sb_responder: three configurations checked against
// a word-array reference model with a per-cycle response scoreboard.
module tb_dm_sb_responder;

    localparam int N = 3;
    localparam int unsigned STALL [N] = '{0, 2, 0};
    localparam int unsigned LAT   [N] = '{1, 3, 2};
    localparam logic [31:0] BASE  [N] = '{32'h0, 32'h1000, 32'h0};
    localparam int unsigned DEPTH = 256;

    typedef struct {
        longint      due;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req     [N];
    logic        we      [N];
    logic [31:0] add     [N];
    logic [31:0] wdata   [N];
    logic [3:0]  be      [N];
    logic        gnt     [N];
    logic        r_valid [N];
    logic [31:0] r_rdata [N];
    logic        r_err   [N];

    exp_t        exp_q [N][$];
    logic [31:0] model_mem [N][DEPTH];
    longint      cyc = 0;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dm_sb_responder #(.BusWidth(32), .MemDepth(256), .BaseAddr(64'h0),
                      .GntStall(0), .RespLatency(1)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .slave_req_i(req[0]), .slave_add_i(add[0]),
        .slave_we_i(we[0]), .slave_wdata_i(wdata[0]), .slave_be_i(be[0]),
        .slave_gnt_o(gnt[0]), .slave_r_valid_o(r_valid[0]),
        .slave_r_rdata_o(r_rdata[0]), .slave_r_err_o(r_err[0]));

    dm_sb_responder #(.BusWidth(32), .MemDepth(256), .BaseAddr(64'h1000),
                      .GntStall(2), .RespLatency(3)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .slave_req_i(req[1]), .slave_add_i(add[1]),
        .slave_we_i(we[1]), .slave_wdata_i(wdata[1]), .slave_be_i(be[1]),
        .slave_gnt_o(gnt[1]), .slave_r_valid_o(r_valid[1]),
        .slave_r_rdata_o(r_rdata[1]), .slave_r_err_o(r_err[1]));

    dm_sb_responder #(.BusWidth(32), .MemDepth(256), .BaseAddr(64'h0),
                      .GntStall(0), .RespLatency(2)) dut2 (
        .clk_i(clk), .rst_ni(rst_n), .slave_req_i(req[2]), .slave_add_i(add[2]),
        .slave_we_i(we[2]), .slave_wdata_i(wdata[2]), .slave_be_i(be[2]),
        .slave_gnt_o(gnt[2]), .slave_r_valid_o(r_valid[2]),
        .slave_r_rdata_o(r_rdata[2]), .slave_r_err_o(r_err[2]));

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Reference model: a plain word array; each granted transfer yields
    // one expected response due LAT cycles later.
    task automatic model_transfer(input int d, input bit w, input logic [31:0] a,
                                  input logic [31:0] wd, input logic [3:0] b, input longint due);
        exp_t        e;
        bit          ok;
        int unsigned word;
        ok   = (a >= BASE[d]) && (((a - BASE[d]) / 4) < DEPTH);
        word = (a - BASE[d]) / 4;
        e.due   = due;
        e.err   = !ok;
        e.rdata = 32'h0;
        if (ok) begin
            if (w) begin
                for (int i = 0; i < 4; i++)
                    if (b[i]) model_mem[d][word][i*8 +: 8] = wd[i*8 +: 8];
            end else begin
                e.rdata = model_mem[d][word];
            end
        end
        exp_q[d].push_back(e);
        $display("txn dut%0d %s addr=0x%08h wdata=0x%08h be=%b -> err=%0d rdata=0x%08h due=%0d",
                 d, w ? "WR" : "RD", a, wd, b, e.err, e.rdata, due);
    endtask

    // Hold a request for up to max_hold cycles; grant must come exactly
    // after STALL[d] cycles of continuous request.
    task automatic do_txn(input int d, input bit w, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] b, input int max_hold);
        int held;
        bit granted;
        held = 0;
        granted = 0;
        while (held < max_hold && !granted) begin
            @(negedge clk);
            req[d] = 1'b1; we[d] = w; add[d] = a; wdata[d] = wd; be[d] = b;
            #1;
            check($sformatf("gnt%0d", d), gnt[d], held == int'(STALL[d]));
            if (gnt[d]) begin
                granted = 1;
                model_transfer(d, w, a, wd, b, cyc + LAT[d]);
            end
            held++;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            for (int d = 0; d < N; d++) req[d] = 1'b0;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        for (int d = 0; d < N; d++) begin
            req[d] = 1'b0;
            exp_q[d].delete();
        end
        @(negedge clk);
        for (int d = 0; d < N; d++) begin
            check($sformatf("rst_rdata%0d", d), r_rdata[d], 32'h0);
            check($sformatf("rst_err%0d", d), r_err[d], 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Scoreboard: every cycle, r_valid must match whether a response is due.
    always @(negedge clk) begin : monitor
        bit due_now;
        for (int d = 0; d < N; d++) begin
            due_now = (exp_q[d].size() > 0) && (exp_q[d][0].due == cyc);
            check($sformatf("r_valid%0d", d), r_valid[d], due_now);
            if (due_now) begin
                check($sformatf("rdata%0d", d), r_rdata[d], exp_q[d][0].rdata);
                check($sformatf("err%0d", d), r_err[d], exp_q[d][0].err);
                exp_q[d].pop_front();
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        rst_n = 1'b0;
        for (int d = 0; d < N; d++) begin
            req[d] = 0; we[d] = 0; add[d] = 0; wdata[d] = 0; be[d] = 0;
        end
        apply_reset();

        // Preload every word so later reads have defined contents.
        for (int d = 0; d < N; d++) begin
            for (int i = 0; i < int'(DEPTH); i++)
                do_txn(d, 1'b1, BASE[d] + 32'(i * 4), $urandom, 4'hF, 8);
            idle(1);
        end
        idle(4);

        // Word round-trip, byte enables, be=0 no-op, ignored LSBs.
        do_txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 8);
        idle(1);
        do_txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 8);
        do_txn(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 8);
        do_txn(0, 1'b1, 32'h20, 32'h0000AA00, 4'b0010, 8);
        do_txn(0, 1'b0, 32'h20, 32'h0, 4'hF, 8);
        do_txn(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, 8);
        do_txn(0, 1'b0, 32'h23, 32'h0, 4'h0, 8);
        idle(3);

        // Stall/latency, withdrawn request, out-of-range window edges.
        do_txn(1, 1'b0, 32'h1010, 32'h0, 4'hF, 8);
        idle(1);
        do_txn(1, 1'b0, 32'h1010, 32'h0, 4'hF, 1);
        idle(1);
        do_txn(1, 1'b0, 32'h1014, 32'h0, 4'hF, 8);
        idle(4);
        do_txn(1, 1'b0, 32'h0FFC, 32'h0, 4'hF, 8);
        do_txn(1, 1'b1, 32'h1400, 32'hFFFFFFFF, 4'hF, 8);
        do_txn(1, 1'b0, 32'h1000, 32'h0, 4'hF, 8);
        do_txn(1, 1'b0, 32'h13FC, 32'h0, 4'hF, 8);
        idle(5);

        // Reset one cycle after a read grant: the response must never appear.
        do_txn(1, 1'b0, 32'h1004, 32'h0, 4'hF, 8);
        apply_reset();
        do_txn(1, 1'b0, 32'h1008, 32'h0, 4'hF, 8);
        idle(5);

        // Back-to-back reads and write-then-read of the same word.
        for (int i = 0; i < 4; i++)
            do_txn(2, 1'b0, 32'(i * 4), 32'h0, 4'hF, 8);
        do_txn(2, 1'b1, 32'h40, 32'hCAFEF00D, 4'hF, 8);
        do_txn(2, 1'b0, 32'h40, 32'h0, 4'h0, 8);
        idle(4);

        // Random traffic.
        for (int d = 0; d < N; d++) begin
            for (int t = 0; t < 100; t++) begin
                if ($urandom_range(0, 7) == 0) begin
                    if (d == 1 && $urandom_range(0, 1) == 1)
                        a = BASE[d] - 32'(4 * $urandom_range(1, 4));
                    else
                        a = BASE[d] + 32'h400 + 32'(4 * $urandom_range(0, 63));
                end else begin
                    a = BASE[d] + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(0, 3));
                end
                if (STALL[d] > 0 && $urandom_range(0, 7) == 0) begin
                    do_txn(d, 1'($urandom), a, $urandom, 4'($urandom), $urandom_range(1, int'(STALL[d])));
                    idle(1);
                end
                do_txn(d, 1'($urandom), a, $urandom, 4'($urandom), 8);
                if ($urandom_range(0, 3) == 0) idle(1);
            end
            idle(1);
        end

        idle(6);
        for (int d = 0; d < N; d++)
            check($sformatf("drained%0d", d), exp_q[d].size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
